itch_feed_arbiter: RTL and testbench
====================================

# itch_feed_arbiter

- Shares one `itch_parser` instance between `NUM_FEEDS` redundant or partitioned 10GbE market-data feeds (e.g. A/B line arbitration inputs).
- Sits between the MAC-side AXI-Stream slaves and the parser's slave port.
- Grants the parser to one feed per packet using round-robin order and holds the grant until that packet's `tlast` beat.
- Forwards beats through one registered output stage, tags each beat with its feed index, and keeps per-feed packet counters.

## Interface
Parameters:
- `NUM_FEEDS`, default 2: number of input feeds, range 2..8.
- `FEED_ID_W`, default `$clog2(NUM_FEEDS)`: width of the feed tag.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `s_axis_tdata`  in  `NUM_FEEDS*AXIS_DATA_WIDTH`  per-feed data; feed i occupies slice i.
- `s_axis_tkeep`  in  `NUM_FEEDS*AXIS_KEEP_WIDTH`  per-feed byte enables.
- `s_axis_tvalid`  in  `NUM_FEEDS`  per-feed valid.
- `s_axis_tlast`  in  `NUM_FEEDS`  per-feed end of packet.
- `s_axis_tready`  out  `NUM_FEEDS`  per-feed ready.
- `m_axis_tdata`  out  `AXIS_DATA_WIDTH`  data to the parser.
- `m_axis_tkeep`  out  `AXIS_KEEP_WIDTH`  byte enables to the parser.
- `m_axis_tvalid`  out  1  valid to the parser.
- `m_axis_tlast`  out  1  end of packet to the parser.
- `m_axis_tready`  in  1  ready from the parser.
- `m_axis_tid`  out  `FEED_ID_W`  index of the feed that sourced the beat.
- `feed_enable`  in  `NUM_FEEDS`  configuration mask; a 0 excludes that feed from arbitration.
- `pkt_count`  out  `NUM_FEEDS*32`  packets forwarded per feed.
- `busy`  out  1  high while a grant is locked.

## Operation
State machine:
- States are `S_ARB` and `S_LOCKED`. Registers are `state`, `grant_idx`, and `last_grant`.

Arbitration in `S_ARB`:
- `req[i] = s_axis_tvalid[i] & feed_enable[i]`.
- The winner is the first requesting feed found by searching upward from `last_grant+1`, modulo `NUM_FEEDS`.
- The winner's first beat is accepted in the same cycle. There is no arbitration bubble.

Acceptance:
- `s_axis_tready[i]` is 1 only for the current winner or locked feed, and only when `!m_axis_tvalid || m_axis_tready`. It is 0 for every other feed.
- When a beat is accepted from feed g:
  - The output register loads data, keep and last from feed g.
  - `m_axis_tid` loads g.
  - `m_axis_tvalid` becomes 1.

Transitions:
- `S_ARB` → `S_LOCKED` when a non-last beat is accepted; `grant_idx` becomes the winner.
- `S_ARB` stays in `S_ARB` when a single-beat packet (`tlast` on the first beat) is accepted. `last_grant` and `pkt_count` still update.
- `S_LOCKED` → `S_ARB` when a beat with `tlast=1` is accepted from `grant_idx`. `last_grant` becomes `grant_idx`.
- When the tlast beat is accepted, `pkt_count[g]` increments. It wraps modulo 2^32.

Locked behaviour:
- The feed in `grant_idx` stays granted even if its `tvalid` drops mid-packet. Other feeds wait.
- `feed_enable` changes affect only the next arbitration. A packet already locked always completes.
- All feeds disabled, or no requests: stay in `S_ARB` with all `tready` low.

Other rules:
- `busy = (state == S_LOCKED)`.
- If the output register holds a beat and `m_axis_tready=0`, the output holds stable: data, keep, last, id and valid do not change.
- Reset mid-packet drops the partial packet. The parser resynchronises on the next frame.

## Timing
Reset values:
- `state=S_ARB`, `last_grant=NUM_FEEDS-1` (feed 0 wins first), `grant_idx=0`.
- All outputs 0: `m_axis_*`, `s_axis_tready`, `pkt_count`, `busy`.

Latency and throughput:
- Latency is 1 cycle from input acceptance to `m_axis_tvalid`.
- Throughput is 1 beat/cycle with `m_axis_tready` held high, including back-to-back packets from different feeds.

Combinational paths:
- `s_axis_tready` is combinational from `m_axis_tready`, `s_axis_tvalid`, `feed_enable` and state. This is the only combinational input-to-output path.

Counter timing:
- `pkt_count` updates on the clock edge that accepts the tlast beat. The new value is visible the cycle after.

## Structure
- `AXIS_DATA_WIDTH` and `AXIS_KEEP_WIDTH` come from `axi_stream_pkg`.
- Add the following to `axi_stream_pkg`:
  - `ITCH_MAX_FEEDS = 8`.
  - An `arb_state_t` enum for the two states.
- `FEED_ID_W` stays a module parameter because it depends on `NUM_FEEDS`.
- One sub-module, `rr_arbiter`: combinational round-robin pick.
  - Inputs: `req`, `last_grant`.
  - Outputs: `grant_valid`, `grant_idx`.
  - Parameterised by `NUM_FEEDS`.

## Test plan
- Single feed, 5-beat Add Order (type 0x41, last beat keep=0xF0) on feed 0 with `m_axis_tready=1`:
  - All 5 beats out, one cycle later, `tid=0`.
  - `pkt_count[0]=1`.
  - The parser asserts `order_valid` once.
- Feeds 0 and 1 both request, each with a 3-beat packet, from reset:
  - Output order is feed 0's 3 beats then feed 1's 3 beats, with no idle cycle between them.
  - `tid` sequence is 0,0,0,1,1,1.
- Feed 1 drops `tvalid` for 4 cycles mid-packet while feed 0 requests:
  - Feed 0's `tready` stays 0 until feed 1's tlast is accepted.
  - `busy` stays 1 throughout.
- `m_axis_tready` low for 3 cycles during a packet:
  - Output data and tid stay stable.
  - The granted feed's `tready` is 0 during the stall.
  - No beat is lost or duplicated.
- `feed_enable=2'b01` while feed 1 has a pending packet; feed_enable is cleared mid-packet on feed 0:
  - Feed 1 never granted.
  - Feed 0's packet completes.
  - After that, no grants are made.
- Reset asserted mid-packet, then 2^32−1 preloaded count rollover via 1 packet:
  - All outputs 0 during reset.
  - After reset, feed 0 wins first.
  - Counter wraps to 0.

Source files
------------

// File: rtl/axi_stream_pkg.sv
// Shared AXI-Stream widths and the types used by the ITCH feed arbiter.
package axi_stream_pkg;

  localparam int AXIS_DATA_WIDTH = 64;
  localparam int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8;

  localparam int ITCH_MAX_FEEDS = 8;

  typedef enum logic {
    S_ARB    = 1'b0,
    S_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/itch_feed_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester found searching upward from
// last_grant+1, wrapping modulo NUM_FEEDS.
module rr_arbiter
  import axi_stream_pkg::*;
#(
  parameter int NUM_FEEDS = 2,
  parameter int ID_W      = $clog2(NUM_FEEDS)
) (
  input  logic [NUM_FEEDS-1:0] req,
  input  logic [ID_W-1:0]      last_grant,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_idx
);

  // Offsets are scanned from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int off = NUM_FEEDS; off >= 1; off--) begin
      for (int j = 0; j < NUM_FEEDS; j++) begin
        if (req[j] && (j == (int'(last_grant) + off) % NUM_FEEDS)) begin
          grant_valid = 1'b1;
          grant_idx   = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/itch_feed_arbiter.sv
// Packet-granular round-robin arbiter sharing one ITCH parser between several
// MAC-side AXI-Stream feeds, with a single registered output stage.
module itch_feed_arbiter
  import axi_stream_pkg::*;
#(
  parameter int NUM_FEEDS = 2,
  parameter int FEED_ID_W = $clog2(NUM_FEEDS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_FEEDS*AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_FEEDS*AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_FEEDS-1:0]                 s_axis_tvalid,
  input  logic [NUM_FEEDS-1:0]                 s_axis_tlast,
  output logic [NUM_FEEDS-1:0]                 s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic [FEED_ID_W-1:0]                 m_axis_tid,
  input  logic [NUM_FEEDS-1:0]                 feed_enable,
  output logic [NUM_FEEDS*32-1:0]              pkt_count,
  output logic                                 busy
);

  arb_state_t                 state_q, state_d;
  logic [FEED_ID_W-1:0]       grant_idx_q, grant_idx_d;
  logic [FEED_ID_W-1:0]       last_grant_q, last_grant_d;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [AXIS_KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                       tvalid_q, tvalid_d;
  logic                       tlast_q, tlast_d;
  logic [FEED_ID_W-1:0]       tid_q, tid_d;

  logic [NUM_FEEDS-1:0]       req;
  logic                       arb_valid;
  logic [FEED_ID_W-1:0]       arb_idx;
  logic                       sel_valid;
  logic [FEED_ID_W-1:0]       sel_idx;
  logic                       out_free;
  logic                       accept;
  logic [AXIS_DATA_WIDTH-1:0] beat_data;
  logic [AXIS_KEEP_WIDTH-1:0] beat_keep;
  logic                       beat_last;
  logic                       beat_valid;

  assign req = s_axis_tvalid & feed_enable;

  rr_arbiter #(
    .NUM_FEEDS (NUM_FEEDS),
    .ID_W      (FEED_ID_W)
  ) u_rr_arbiter (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  // A locked feed keeps its grant regardless of tvalid or feed_enable.
  assign out_free  = !tvalid_q || m_axis_tready;
  assign sel_valid = (state_q == S_LOCKED) || arb_valid;
  assign sel_idx   = (state_q == S_LOCKED) ? grant_idx_q : arb_idx;

  generate
    for (genvar gi = 0; gi < NUM_FEEDS; gi++) begin : gen_ready
      // rst_n keeps every tready low while reset is held.
      assign s_axis_tready[gi] = rst_n && out_free && sel_valid &&
                                 (sel_idx == FEED_ID_W'(gi));
    end
  endgenerate

  always_comb begin
    beat_data  = '0;
    beat_keep  = '0;
    beat_last  = 1'b0;
    beat_valid = 1'b0;
    for (int i = 0; i < NUM_FEEDS; i++) begin
      if (sel_idx == FEED_ID_W'(i)) begin
        beat_data  = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        beat_keep  = s_axis_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
        beat_last  = s_axis_tlast[i];
        beat_valid = s_axis_tvalid[i];
      end
    end
  end

  assign accept = sel_valid && out_free && beat_valid;

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    tdata_d      = tdata_q;
    tkeep_d      = tkeep_q;
    tlast_d      = tlast_q;
    tid_d        = tid_q;
    tvalid_d     = tvalid_q;

    if (accept) begin
      tdata_d  = beat_data;
      tkeep_d  = beat_keep;
      tlast_d  = beat_last;
      tid_d    = sel_idx;
      tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    if (accept) begin
      if (state_q == S_ARB) begin
        if (beat_last) begin
          last_grant_d = sel_idx;
        end else begin
          state_d     = S_LOCKED;
          grant_idx_d = sel_idx;
        end
      end else if (beat_last) begin
        state_d      = S_ARB;
        last_grant_d = grant_idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_ARB;
      grant_idx_q  <= '0;
      last_grant_q <= FEED_ID_W'(NUM_FEEDS - 1);
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tlast_q      <= 1'b0;
      tid_q        <= '0;
      tvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
      tlast_q      <= tlast_d;
      tid_q        <= tid_d;
      tvalid_q     <= tvalid_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_FEEDS; gi++) begin : gen_cnt
      logic [31:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (accept && beat_last && (sel_idx == FEED_ID_W'(gi))) begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign pkt_count[gi*32 +: 32] = cnt_q;
    end
  endgenerate

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tid    = tid_q;
  assign busy          = (state_q == S_LOCKED);

endmodule

// File: tb/tb_itch_feed_arbiter.sv
// Scoreboard bench for itch_feed_arbiter: directed packets per feed, expected
// beats queued by each test, popped and compared by a free-running monitor.
module tb_itch_feed_arbiter;
  import axi_stream_pkg::*;

  localparam int NF = 2;
  localparam int DW = AXIS_DATA_WIDTH;
  localparam int KW = AXIS_KEEP_WIDTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NF*DW-1:0]  s_axis_tdata;
  logic [NF*KW-1:0]  s_axis_tkeep;
  logic [NF-1:0]     s_axis_tvalid;
  logic [NF-1:0]     s_axis_tlast;
  logic [NF-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b1;
  logic [0:0]        m_axis_tid;
  logic [NF-1:0]     feed_enable = 2'b11;
  logic [NF*32-1:0]  pkt_count;
  logic              busy;

  logic [DW-1:0] fd_data  [NF];
  logic [KW-1:0] fd_keep  [NF];
  logic          fd_valid [NF];
  logic          fd_last  [NF];

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [0:0]    tid;
  } beat_t;

  beat_t exp_q[$];
  int    pop_cyc[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    acc_cyc [NF];
  bit    f_started [NF];
  bit    f_done [NF];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NF; gi++) begin : gen_pack
      assign s_axis_tdata[gi*DW +: DW] = fd_data[gi];
      assign s_axis_tkeep[gi*KW +: KW] = fd_keep[gi];
      assign s_axis_tvalid[gi]         = fd_valid[gi];
      assign s_axis_tlast[gi]          = fd_last[gi];
    end
  endgenerate

  itch_feed_arbiter #(.NUM_FEEDS(NF)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .m_axis_tid    (m_axis_tid),
    .feed_enable   (feed_enable),
    .pkt_count     (pkt_count),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops one expected beat per output handshake; also checks that a
  // stalled output holds its contents.
  initial begin
    beat_t e;
    beat_t hold_b;
    bit    hold_v;
    hold_v = 1'b0;
    hold_b = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("stall_data", m_axis_tdata, hold_b.data);
          check("stall_tid", m_axis_tid, hold_b.tid);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %h tid %0d, expected no beat", m_axis_tdata, m_axis_tid);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", m_axis_tdata, e.data);
            check("beat_keep", m_axis_tkeep, e.keep);
            check("beat_last", m_axis_tlast, e.last);
            check("beat_tid", m_axis_tid, e.tid);
            pop_cyc.push_back(cyc);
            $display("beat  cyc=%0d tid=%0d data=%h keep=%h last=%0d", cyc, m_axis_tid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
          end
          hold_v = 1'b0;
        end else if (m_axis_tvalid) begin
          hold_v = 1'b1;
          hold_b = '{data: m_axis_tdata, keep: m_axis_tkeep, last: m_axis_tlast, tid: m_axis_tid};
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic exp_pkt(input int tid, input int n, input logic [63:0] base, input logic [7:0] lkeep);
    beat_t e;
    for (int b = 0; b < n; b++) begin
      e.data = base + 64'(b);
      e.keep = (b == n - 1) ? lkeep : 8'hFF;
      e.last = (b == n - 1);
      e.tid  = 1'(tid);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_flags();
    for (int i = 0; i < NF; i++) begin
      f_started[i] = 1'b0;
      f_done[i]    = 1'b0;
    end
    pop_cyc.delete();
  endtask

  task automatic send_pkt(input int f, input int n, input logic [63:0] base, input logic [7:0] lkeep,
                          input int gap_at, input int gap_len);
    int t;
    for (int b = 0; b < n; b++) begin
      if (b == gap_at) begin
        fd_valid[f] = 1'b0;
        repeat (gap_len) begin
          @(posedge clk);
          #1;
        end
      end
      fd_valid[f] = 1'b1;
      fd_data[f]  = base + 64'(b);
      fd_keep[f]  = (b == n - 1) ? lkeep : 8'hFF;
      fd_last[f]  = (b == n - 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!s_axis_tready[f] && t < 100);
      if (!s_axis_tready[f]) begin
        checks++;
        errors++;
        $display("FAIL feed%0d_accept: got tready 0 for 100 cycles expected 1", f);
        fd_valid[f] = 1'b0;
        f_done[f]   = 1'b1;
        return;
      end
      if (b == 0) acc_cyc[f] = cyc;
      @(posedge clk);
      #1;
      if (b == 0) f_started[f] = 1'b1;
    end
    fd_valid[f] = 1'b0;
    fd_last[f]  = 1'b0;
    f_done[f]   = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    int t;
    for (int i = 0; i < NF; i++) begin
      fd_data[i]  = '0;
      fd_keep[i]  = '0;
      fd_valid[i] = 1'b0;
      fd_last[i]  = 1'b0;
    end
    clear_flags();

    // Reset state with a feed requesting: nothing may be accepted.
    fd_valid[0] = 1'b1;
    #12;
    check("rst_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_count", pkt_count, 0);
    fd_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 5-beat Add Order on feed 0.
    clear_flags();
    exp_pkt(0, 5, 64'h4100_0000_0000_1000, 8'hF0);
    send_pkt(0, 5, 64'h4100_0000_0000_1000, 8'hF0, -1, 0);
    wait_drain("t1_drained");
    check("t1_pops", pop_cyc.size(), 5);
    if (pop_cyc.size() == 5) begin
      check("t1_latency", 64'(pop_cyc[0] - acc_cyc[0]), 1);
      check("t1_span", 64'(pop_cyc[4] - pop_cyc[0]), 4);
    end
    check("t1_pkt_count0", pkt_count[31:0], 1);
    check("t1_busy", busy, 0);

    // Both feeds from reset: feed 0 first, back-to-back.
    do_reset();
    @(posedge clk);
    #1;
    clear_flags();
    exp_pkt(0, 3, 64'hA0A0_0000_0000_0000, 8'hFF);
    exp_pkt(1, 3, 64'hB1B1_0000_0000_0000, 8'h3F);
    fork
      send_pkt(0, 3, 64'hA0A0_0000_0000_0000, 8'hFF, -1, 0);
      send_pkt(1, 3, 64'hB1B1_0000_0000_0000, 8'h3F, -1, 0);
    join
    wait_drain("t2_drained");
    check("t2_pops", pop_cyc.size(), 6);
    if (pop_cyc.size() == 6) check("t2_span", 64'(pop_cyc[5] - pop_cyc[0]), 5);
    check("t2_pkt_count0", pkt_count[31:0], 1);
    check("t2_pkt_count1", pkt_count[63:32], 1);

    // Feed 1 locked and drops tvalid mid-packet while feed 0 requests.
    clear_flags();
    exp_pkt(1, 4, 64'hC1C1_0000_0000_0000, 8'h0F);
    exp_pkt(0, 2, 64'hC0C0_0000_0000_0000, 8'hFF);
    fork
      send_pkt(1, 4, 64'hC1C1_0000_0000_0000, 8'h0F, 2, 4);
      begin
        wait (f_started[1] || f_done[1]);
        send_pkt(0, 2, 64'hC0C0_0000_0000_0000, 8'hFF, -1, 0);
      end
      begin
        wait (f_started[1] || f_done[1]);
        t = 0;
        while (!f_done[1] && t < 200) begin
          @(negedge clk);
          t++;
          if (!f_done[1]) begin
            check("t3_tready0_held", s_axis_tready[0], 0);
            check("t3_busy", busy, 1);
          end
        end
      end
    join
    wait_drain("t3_drained");
    check("t3_pkt_count1", pkt_count[63:32], 2);

    // Output stall for 3 cycles mid-packet.
    clear_flags();
    exp_pkt(0, 4, 64'hD0D0_0000_0000_0000, 8'h01);
    fork
      send_pkt(0, 4, 64'hD0D0_0000_0000_0000, 8'h01, -1, 0);
      begin
        wait (f_started[0] || f_done[0]);
        m_axis_tready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("t4_stall_tready", s_axis_tready[0], 0);
          check("t4_stall_valid", m_axis_tvalid, 1);
          check("t4_stall_tid", m_axis_tid, 0);
        end
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
      end
    join
    wait_drain("t4_drained");
    check("t4_pkt_count0", pkt_count[31:0], 3);

    // Feed 1 masked and pending; mask cleared while feed 0 is locked.
    clear_flags();
    feed_enable = 2'b01;
    fd_data[1]  = 64'hEEEE_0000_0000_0000;
    fd_keep[1]  = 8'hFF;
    fd_last[1]  = 1'b1;
    fd_valid[1] = 1'b1;
    exp_pkt(0, 3, 64'hE0E0_0000_0000_0000, 8'h7F);
    fork
      send_pkt(0, 3, 64'hE0E0_0000_0000_0000, 8'h7F, -1, 0);
      begin
        wait (f_started[0] || f_done[0]);
        feed_enable = 2'b00;
      end
      begin
        t = 0;
        while (!f_done[0] && t < 200) begin
          @(negedge clk);
          t++;
          check("t5_tready1", s_axis_tready[1], 0);
        end
      end
    join
    wait_drain("t5_drained");
    repeat (4) begin
      @(negedge clk);
      check("t5_no_grant", s_axis_tready, 0);
      check("t5_idle_busy", busy, 0);
      check("t5_idle_valid", m_axis_tvalid, 0);
    end
    check("t5_pkt_count1", pkt_count[63:32], 2);
    @(posedge clk);
    #1;
    fd_valid[1] = 1'b0;
    fd_last[1]  = 1'b0;
    feed_enable = 2'b11;

    // Reset in the middle of a feed 1 packet, then counter wrap on feed 0.
    clear_flags();
    exp_pkt(1, 1, 64'hF1F1_0000_0000_0000, 8'hFF);
    exp_q[0].last = 1'b0;
    fd_data[1]  = 64'hF1F1_0000_0000_0000;
    fd_keep[1]  = 8'hFF;
    fd_last[1]  = 1'b0;
    fd_valid[1] = 1'b1;
    @(negedge clk);
    check("t6_first_tready1", s_axis_tready[1], 1);
    @(posedge clk);
    #1;
    fd_data[1] = 64'hF1F1_0000_0000_0001;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    fd_data[0]  = 64'h0C0C_0000_0000_0000;
    fd_keep[0]  = 8'h0F;
    fd_last[0]  = 1'b1;
    fd_valid[0] = 1'b1;
    #1;
    check("t6_drained_pre_reset", exp_q.size(), 0);
    check("t6_rst_tready", s_axis_tready, 0);
    check("t6_rst_tvalid", m_axis_tvalid, 0);
    check("t6_rst_tdata", m_axis_tdata, 0);
    check("t6_rst_tkeep", m_axis_tkeep, 0);
    check("t6_rst_tlast", m_axis_tlast, 0);
    check("t6_rst_tid", m_axis_tid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pkt_count", pkt_count, 0);
    fd_valid[0] = 1'b0;
    fd_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Preload feed 0's counter to 2^32-1 without a dedicated load port.
    force dut.gen_cnt[0].cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.gen_cnt[0].cnt_q;
    #1;
    check("t6_preload", pkt_count[31:0], 64'hFFFF_FFFF);
    exp_pkt(0, 1, 64'h0C0C_0000_0000_0000, 8'h0F);
    fd_valid[0] = 1'b1;
    fd_data[1]  = 64'h0D0D_0000_0000_0000;
    fd_last[1]  = 1'b0;
    fd_valid[1] = 1'b1;
    @(negedge clk);
    check("t6_first_win_tready0", s_axis_tready[0], 1);
    check("t6_first_win_tready1", s_axis_tready[1], 0);
    @(posedge clk);
    #1;
    fd_valid[0] = 1'b0;
    fd_valid[1] = 1'b0;
    @(negedge clk);
    check("t6_wrap", pkt_count[31:0], 0);
    check("t6_single_beat_busy", busy, 0);
    wait_drain("t6_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
